// File: rtl/perf_counter_controller.sv
// perf_counter_controller: IO-mapped event routing, enable, sequenced clear and sticky overflow
// status for the core performance counters. Define PERF_OVERFLOW_INT_EN to add INTEN and the IRQ.
module perf_counter_controller #(
  parameter int          NUM_EVENTS   = 16,
  parameter int          NUM_COUNTERS = 4,
  parameter int          PRFC_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] perf_events,
  input  logic [31:0]           io_address,
  input  logic                  io_write_en,
  input  logic [31:0]           io_write_data,
  input  logic                  io_read_en,
  output logic [31:0]           io_read_data,
  output logic                  perf_overflow_int
);

  localparam int SEL_W = $clog2(NUM_EVENTS);
  localparam int IDX_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [7:0] OFF_CTRL  = 8'h00;
  localparam logic [7:0] OFF_OVF   = 8'h04;
  localparam logic [7:0] OFF_INTEN = 8'h08;

  logic [31:0]                   offset;
  logic [7:0]                    off_lo;
  logic                          hit;
  logic                          ctrl_wr;
  logic                          ovf_wr;
  logic [0:0]                    state_reg;
  logic [0:0]                    state_next;
  logic [IDX_W-1:0]              idx_reg;
  logic [IDX_W-1:0]              idx_next;
  logic                          enable_reg;
  logic                          busy;
  logic                          count_en;
  logic [NUM_COUNTERS-1:0]       ovf_reg;
  logic [NUM_COUNTERS-1:0]       ovf_next;
  logic [NUM_COUNTERS-1:0]       ovf_w1c;
  logic [NUM_COUNTERS-1:0]       wrap_vec;
  logic [NUM_COUNTERS-1:0][31:0] sel_rd;
  logic [NUM_COUNTERS-1:0][31:0] cnt_rd;
  logic [31:0]                   inten_rd;
  logic [31:0]                   rd_mux;
  logic [31:0]                   read_data_reg;
  logic                          unused_wdata;

  // Unsigned wrap makes addresses below the base land far outside the 256-byte window.
  assign offset       = io_address - BASE_ADDRESS;
  assign off_lo       = offset[7:0];
  assign hit          = (offset[31:8] == 24'd0);
  assign ctrl_wr      = io_write_en && hit && (off_lo == OFF_CTRL);
  assign ovf_wr       = io_write_en && hit && (off_lo == OFF_OVF);
  assign busy         = (state_reg == ST_CLEAR);
  assign count_en     = !busy && enable_reg;
  assign unused_wdata = ^io_write_data;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ctrl_wr && io_write_data[1]) begin
          state_next = ST_CLEAR;
          idx_next   = '0;
        end
      end
      ST_CLEAR: begin
        if (idx_reg == IDX_W'(NUM_COUNTERS - 1)) begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // A fresh wrap beats a simultaneous write-1-to-clear of the same bit.
  assign ovf_w1c  = ovf_wr ? io_write_data[NUM_COUNTERS-1:0] : '0;
  assign ovf_next = (ovf_reg & ~ovf_w1c) | wrap_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      enable_reg <= 1'b0;
      ovf_reg    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ovf_reg   <= ovf_next;
      if (ctrl_wr) begin
        enable_reg <= io_write_data[0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_ctr
      localparam logic [7:0] SEL_OFF = 8'(64 + 4 * gi);
      localparam logic [7:0] CNT_OFF = 8'(128 + 4 * gi);

      logic [SEL_W-1:0]      sel_reg;
      logic [PRFC_WIDTH-1:0] cnt_reg;
      logic                  sel_wr;
      logic                  evt_hit;
      logic                  clr_hit;

      assign sel_wr       = io_write_en && hit && (off_lo == SEL_OFF);
      // Old selection applies to this cycle's event even when SEL is being rewritten.
      assign evt_hit      = count_en && perf_events[sel_reg];
      assign clr_hit      = busy && (idx_reg == IDX_W'(gi));
      assign wrap_vec[gi] = evt_hit && (&cnt_reg);

      always_ff @(posedge clk) begin
        if (reset) begin
          sel_reg <= '0;
          cnt_reg <= '0;
        end else begin
          if (sel_wr) begin
            sel_reg <= io_write_data[SEL_W-1:0];
          end
          if (clr_hit) begin
            cnt_reg <= '0;
          end else if (evt_hit) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign sel_rd[gi] = (off_lo == SEL_OFF) ? 32'(sel_reg) : 32'd0;
      assign cnt_rd[gi] = (off_lo == CNT_OFF) ? 32'(cnt_reg) : 32'd0;
    end
  endgenerate

`ifdef PERF_OVERFLOW_INT_EN
  logic [NUM_COUNTERS-1:0] inten_reg;
  logic                    int_reg;
  logic                    inten_wr;

  assign inten_wr = io_write_en && hit && (off_lo == OFF_INTEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      inten_reg <= '0;
      int_reg   <= 1'b0;
    end else begin
      int_reg <= |(ovf_reg & inten_reg);
      if (inten_wr) begin
        inten_reg <= io_write_data[NUM_COUNTERS-1:0];
      end
    end
  end

  assign inten_rd          = (off_lo == OFF_INTEN) ? 32'(inten_reg) : 32'd0;
  assign perf_overflow_int = int_reg;
`else
  assign inten_rd          = 32'd0;
  assign perf_overflow_int = 1'b0;
`endif

  always_comb begin
    rd_mux = 32'd0;
    if (off_lo == OFF_CTRL) begin
      rd_mux = {29'd0, busy, 1'b0, enable_reg};
    end
    if (off_lo == OFF_OVF) begin
      rd_mux = 32'(ovf_reg);
    end
    rd_mux = rd_mux | inten_rd;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      rd_mux = rd_mux | sel_rd[i] | cnt_rd[i];
    end
    if (!hit) begin
      rd_mux = 32'd0;
    end
  end

  // Read samples pre-write state; the result holds until the next read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_reg <= 32'd0;
    end else if (io_read_en) begin
      read_data_reg <= rd_mux;
    end
  end

  assign io_read_data = read_data_reg;

endmodule
